// File: rtl/memory_pkg.sv
// rtl/memory_pkg.sv - shared widths, depth and word/address types for the RAM
package memory_pkg;

  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 8;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

endpackage

// File: rtl/memory_intf.sv
// rtl/memory_intf.sv - signal bundles for the RAM request and read-data sides
interface input_intf;
  import memory_pkg::*;

  logic  enable;
  logic  write;
  addr_t address;
  data_t data_in;
endinterface

interface output_intf;
  import memory_pkg::*;

  data_t data_out;
endinterface

// File: rtl/memory_array.sv
// rtl/memory_array.sv - storage array with write port, whole-array clear and async read tap
module memory_array
  import memory_pkg::*;
#(
  parameter int AW = ADDR_WIDTH,
  parameter int DW = DATA_WIDTH
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] address,
  input  logic [DW-1:0] data_in,
  output logic [DW-1:0] rd_data
);

  localparam int WORDS = 2 ** AW;

  logic [DW-1:0] mem [WORDS];

  // Reset clears every word and wins over a simultaneous write; otherwise store on request
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[address] <= data_in;
    end
  end

  // Read tap is combinational; the top registers it only on read cycles
  assign rd_data = mem[address];

endmodule

// File: rtl/memory.sv
// rtl/memory.sv - single-port synchronous RAM with registered read data
module memory
  import memory_pkg::*;
#(
  parameter int AW = ADDR_WIDTH,
  parameter int DW = DATA_WIDTH
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic          write,
  input  logic [AW-1:0] address,
  input  logic [DW-1:0] data_in,
  output logic [DW-1:0] data_out
);

  logic          wr_en;
  logic          rd_en;
  logic [DW-1:0] rd_data;

  assign wr_en = enable & write;
  assign rd_en = enable & ~write;

  memory_array #(
    .AW (AW),
    .DW (DW)
  ) u_array (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_en),
    .address (address),
    .data_in (data_in),
    .rd_data (rd_data)
  );

  // Output register: cleared by reset, loaded only on read cycles, held on writes and idle
  always_ff @(posedge clock) begin
    if (reset) begin
      data_out <= '0;
    end else if (rd_en) begin
      data_out <= rd_data;
    end
  end

endmodule

// File: tb/tb_memory.sv
// tb/tb_memory.sv - directed and randomized self-checking bench for the RAM
module tb_memory;
  import memory_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;

  input_intf  in_if ();
  output_intf out_if ();

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain word array plus the last value read out
  data_t ref_mem [DEPTH];
  data_t ref_out;

  always #5 clock = ~clock;

  memory dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (in_if.enable),
    .write    (in_if.write),
    .address  (in_if.address),
    .data_in  (in_if.data_in),
    .data_out (out_if.data_out)
  );

  task automatic check(input string tag, input data_t observed, input data_t expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One clock: drive on the falling edge, advance the model, compare shortly after the rising edge
  task automatic step(input logic rst, input logic en, input logic wr,
                      input addr_t a, input data_t d, input string tag);
    @(negedge clock);
    reset          = rst;
    in_if.enable   = en;
    in_if.write    = wr;
    in_if.address  = a;
    in_if.data_in  = d;
    @(posedge clock);
    #1;
    if (rst) begin
      foreach (ref_mem[i]) ref_mem[i] = '0;
      ref_out = '0;
    end else if (en && wr) begin
      ref_mem[a] = d;
    end else if (en) begin
      ref_out = ref_mem[a];
    end
    check(tag, out_if.data_out, ref_out);
  endtask

  initial begin
    foreach (ref_mem[i]) ref_mem[i] = 8'hxx;
    ref_out        = 8'hxx;
    in_if.enable   = 1'b0;
    in_if.write    = 1'b0;
    in_if.address  = '0;
    in_if.data_in  = '0;

    // Reset state
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, "reset0");
    step(1'b1, 1'b1, 1'b1, 8'h00, 8'hFF, "reset1");
    check("reset_out", out_if.data_out, 8'h00);

    // Read of a never-written word
    step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, "read_unwritten");
    check("read_unwritten_c", out_if.data_out, 8'h00);

    // Write then immediate read, then idle hold
    step(1'b0, 1'b1, 1'b1, 8'h10, 8'hA5, "wr_10");
    step(1'b0, 1'b1, 1'b0, 8'h10, 8'h00, "rd_10");
    check("rd_10_c", out_if.data_out, 8'hA5);
    step(1'b0, 1'b0, 1'b0, 8'h10, 8'h00, "idle_hold");
    check("idle_hold_c", out_if.data_out, 8'hA5);

    // Fill with address pattern, read back to back
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b1, 1'b1, addr_t'(i), data_t'(i), "fill");
    end
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b1, 1'b0, addr_t'(i), 8'h00, "sweep");
      check("sweep_c", out_if.data_out, data_t'(i));
    end
    check("top_word", out_if.data_out, 8'hFF);

    // Write leaves data_out untouched
    step(1'b0, 1'b1, 1'b0, 8'h05, 8'h00, "rd_05");
    check("rd_05_c", out_if.data_out, 8'h05);
    step(1'b0, 1'b1, 1'b1, 8'h40, 8'h3C, "wr_hold");
    check("wr_hold_c", out_if.data_out, 8'h05);
    step(1'b0, 1'b1, 1'b0, 8'h40, 8'h00, "rd_40");
    check("rd_40_c", out_if.data_out, 8'h3C);

    // Disabled write must be ignored
    step(1'b0, 1'b1, 1'b1, 8'h20, 8'h77, "wr_20");
    step(1'b0, 1'b0, 1'b1, 8'h20, 8'h11, "disabled_wr");
    step(1'b0, 1'b1, 1'b0, 8'h20, 8'h00, "rd_20");
    check("rd_20_c", out_if.data_out, 8'h77);

    // Reset overrides a simultaneous write and clears the array
    step(1'b0, 1'b1, 1'b1, 8'h05, 8'h55, "wr_05");
    step(1'b1, 1'b1, 1'b1, 8'h05, 8'h66, "rst_wr");
    check("rst_wr_c", out_if.data_out, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h05, 8'h00, "rd_after_rst");
    check("rd_after_rst_c", out_if.data_out, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'hFF, 8'h00, "rd_ff_cleared");
    check("rd_ff_cleared_c", out_if.data_out, 8'h00);

    // Randomized traffic on a narrow address window to force reuse, with rare resets
    for (int i = 0; i < 600; i++) begin
      logic  r_rst, r_en, r_wr;
      addr_t r_a;
      data_t r_d;
      r_rst = ($urandom_range(0, 59) == 0);
      r_en  = ($urandom_range(0, 3) != 0);
      r_wr  = $urandom_range(0, 1) == 1;
      r_a   = ($urandom_range(0, 1) == 1) ? addr_t'($urandom_range(0, 15)) : addr_t'($urandom);
      r_d   = data_t'($urandom);
      step(r_rst, r_en, r_wr, r_a, r_d, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
